// File: rtl/flash_cmd_pkg.sv
// flash_cmd_pkg: shared encodings, JEDEC unlock/command constants and the
// (op, step) -> (address, data) command-list lookup.
package flash_cmd_pkg;

  typedef enum logic [1:0] {
    OP_PROG = 2'd0,
    OP_SECT = 2'd1,
    OP_CHIP = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    POLL_RD,
    POLL_GAP,
    FIN
  } state_e;

  localparam logic [18:0] UNLOCK_A1 = 19'h05555;
  localparam logic [18:0] UNLOCK_A2 = 19'h02AAA;

  localparam logic [7:0] CMD_AA    = 8'hAA;
  localparam logic [7:0] CMD_55    = 8'h55;
  localparam logic [7:0] CMD_PROG  = 8'hA0;
  localparam logic [7:0] CMD_ERASE = 8'h80;
  localparam logic [7:0] CMD_SECT  = 8'h30;
  localparam logic [7:0] CMD_CHIP  = 8'h10;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } bus_word_t;

  function automatic logic [2:0] step_count(input op_e op);
    return (op == OP_PROG) ? 3'd4 : 3'd6;
  endfunction

  function automatic bus_word_t cmd_entry(input op_e op, input logic [2:0] step,
                                          input logic [18:0] addr, input logic [7:0] data);
    bus_word_t w;
    w.addr = UNLOCK_A1;
    w.data = CMD_AA;
    case (step)
      3'd0: begin w.addr = UNLOCK_A1; w.data = CMD_AA; end
      3'd1: begin w.addr = UNLOCK_A2; w.data = CMD_55; end
      3'd2: begin w.addr = UNLOCK_A1; w.data = (op == OP_PROG) ? CMD_PROG : CMD_ERASE; end
      3'd3: begin
        w.addr = (op == OP_PROG) ? addr : UNLOCK_A1;
        w.data = (op == OP_PROG) ? data : CMD_AA;
      end
      3'd4: begin w.addr = UNLOCK_A2; w.data = CMD_55; end
      default: begin
        w.addr = (op == OP_SECT) ? {addr[18:12], 12'h000} : UNLOCK_A1;
        w.data = (op == OP_SECT) ? CMD_SECT : CMD_CHIP;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/flash_cmd_seq_bus.sv
// flash_bus_cycle: per-phase down-counter plus the registered flash strobes,
// address and write-data drivers.
module flash_bus_cycle
  import flash_cmd_pkg::*;
(
  input  logic             fast_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cyc_len,
  input  logic             ce_req,
  input  logic             oe_req,
  input  logic             we_req,
  input  logic             drv_req,
  input  logic [18:0]      addr_in,
  input  logic [7:0]       data_in,
  output logic             busy,
  output logic             last,
  output logic             ce_n,
  output logic             oe_n,
  output logic             we_n,
  output logic             drv,
  output logic [18:0]      addr,
  output logic [7:0]       data
);

  logic [CNT_W-1:0] cnt;

  // oe/we interlock and the tristate gate are enforced here, at the pins
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      cnt  <= '0;
      ce_n <= 1'b1;
      oe_n <= 1'b1;
      we_n <= 1'b1;
      drv  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      if (start)
        cnt <= cyc_len;
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
      ce_n <= ~ce_req;
      oe_n <= ~(oe_req & ~we_req);
      we_n <= ~(we_req & ~oe_req);
      drv  <= drv_req & ~oe_req;
      if (start && ce_req)
        addr <= addr_in;
      if (start && drv_req)
        data <= data_in;
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == '0);

endmodule

// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq: plays JEDEC program/erase command lists on the flash bus,
// then polls DQ7 until completion or timeout.
//   state    | meaning
//   IDLE     | ready, waiting for req
//   WR_SETUP | address/data/_ce valid ahead of _we
//   WR_PULSE | _we low
//   WR_HOLD  | _we released, address/data held one cycle
//   POLL_RD  | status read, DQ7 sampled on the last cycle
//   POLL_GAP | all strobes high between reads
//   FIN      | one-cycle done (error on illegal op or timeout)
module flash_cmd_seq
  import flash_cmd_pkg::*;
#(
  parameter int SETUP_CYC    = 2,
  parameter int WE_PULSE_CYC = 4,
  parameter int READ_CYC     = 3,
  parameter int TIMEOUT_CYC  = 2000000
) (
  input  logic        fast_clock,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic        _ce_flash,
  output logic        _oe_flash,
  output logic        _we_flash,
  output logic [18:0] baddress,
  output logic [7:0]  bdata_out,
  output logic        bdata_oe,
  input  logic [7:0]  bdata_in
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e           state, state_nxt;
  op_e              op_r, op_eff;
  logic [18:0]      addr_r, addr_eff, poll_addr, addr_req;
  logic [7:0]       data_r, data_eff;
  logic [2:0]       step, step_nxt;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_hit, dq7_ok, err_nxt;
  bus_word_t        cmd;
  logic             cyc_start, cyc_busy, cyc_last;
  logic [CNT_W-1:0] cyc_len;
  logic             ce_req, oe_req, we_req, drv_req;
  logic             unused_dq;

  assign unused_dq = ^bdata_in[6:0];

  // While idle, step 0 is driven straight from the request so it lands on the accept edge
  assign op_eff    = (state == IDLE) ? op_e'(op) : op_r;
  assign addr_eff  = (state == IDLE) ? req_addr : addr_r;
  assign data_eff  = (state == IDLE) ? req_data : data_r;
  assign cmd       = cmd_entry(op_eff, step_nxt, addr_eff, data_eff);
  assign poll_addr = (op_r == OP_PROG) ? addr_r :
                     (op_r == OP_SECT) ? {addr_r[18:12], 12'h000} : '0;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign dq7_ok    = (bdata_in[7] == ((op_r == OP_PROG) ? data_r[7] : 1'b1));
  assign cyc_start = (state_nxt != state);

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state   <= IDLE;
      step    <= '0;
      tmo_cnt <= '0;
      op_r    <= OP_PROG;
      addr_r  <= '0;
      data_r  <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      if (state == IDLE && req) begin
        op_r   <= op_e'(op);
        addr_r <= req_addr;
        data_r <= req_data;
      end
      if (state == WR_HOLD)
        tmo_cnt <= '0;
      else if (state == POLL_RD || state == POLL_GAP)
        tmo_cnt <= tmo_cnt + TW'(1);
      ready <= (state_nxt == IDLE);
      done  <= (state_nxt == FIN);
      error <= (state_nxt == FIN) && err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (op_e'(op) == OP_ILL) begin
            state_nxt = FIN;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = WR_SETUP;
            step_nxt  = '0;
          end
        end
      end
      WR_SETUP: if (cyc_last) state_nxt = WR_PULSE;
      WR_PULSE: if (cyc_last) state_nxt = WR_HOLD;
      WR_HOLD: begin
        if (!cyc_busy) begin
          if (step == step_count(op_r) - 3'd1) begin
            state_nxt = POLL_RD;
          end else begin
            state_nxt = WR_SETUP;
            step_nxt  = step + 3'd1;
          end
        end
      end
      POLL_RD: begin
        if (cyc_last && dq7_ok) begin
          state_nxt = FIN;
        end else if (tmo_hit) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else if (cyc_last) begin
          state_nxt = POLL_GAP;
        end
      end
      POLL_GAP: begin
        if (tmo_hit) begin
          state_nxt = FIN;
          err_nxt   = 1'b1;
        end else if (!cyc_busy) begin
          state_nxt = POLL_RD;
        end
      end
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Pin requests follow the state being entered; the bus module registers them
  always_comb begin
    ce_req   = 1'b0;
    oe_req   = 1'b0;
    we_req   = 1'b0;
    drv_req  = 1'b0;
    cyc_len  = '0;
    addr_req = cmd.addr;
    unique case (state_nxt)
      WR_SETUP: begin
        ce_req  = 1'b1;
        drv_req = 1'b1;
        cyc_len = CNT_W'(SETUP_CYC - 1);
      end
      WR_PULSE: begin
        ce_req  = 1'b1;
        we_req  = 1'b1;
        drv_req = 1'b1;
        cyc_len = CNT_W'(WE_PULSE_CYC - 1);
      end
      WR_HOLD: begin
        ce_req  = 1'b1;
        drv_req = 1'b1;
      end
      POLL_RD: begin
        ce_req   = 1'b1;
        oe_req   = 1'b1;
        cyc_len  = CNT_W'(READ_CYC - 1);
        addr_req = poll_addr;
      end
      default: ;
    endcase
  end

  flash_bus_cycle u_bus (
    .fast_clock (fast_clock),
    .reset      (reset),
    .start      (cyc_start),
    .cyc_len    (cyc_len),
    .ce_req     (ce_req),
    .oe_req     (oe_req),
    .we_req     (we_req),
    .drv_req    (drv_req),
    .addr_in    (addr_req),
    .data_in    (cmd.data),
    .busy       (cyc_busy),
    .last       (cyc_last),
    .ce_n       (_ce_flash),
    .oe_n       (_oe_flash),
    .we_n       (_we_flash),
    .drv        (bdata_oe),
    .addr       (baddress),
    .data       (bdata_out)
  );

endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb_flash_cmd_seq: directed and randomized program/erase requests against a
// flash-side observer and a command-list reference model.
module tb_flash_cmd_seq;

  localparam int TMO      = 100;
  localparam int WR_CYC   = 2 + 4 + 1;
  localparam int POLL_PER = 3 + 1;

  logic        fast_clock = 1'b0;
  logic        reset      = 1'b1;
  logic        req        = 1'b0;
  logic [1:0]  op         = '0;
  logic [18:0] req_addr   = '0;
  logic [7:0]  req_data   = '0;
  logic [7:0]  bdata_in   = '0;
  logic        ready, done, error, _ce_flash, _oe_flash, _we_flash, bdata_oe;
  logic [18:0] baddress;
  logic [7:0]  bdata_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  flash_cmd_seq #(.TIMEOUT_CYC(TMO)) dut (
    .fast_clock (fast_clock),
    .reset      (reset),
    .req        (req),
    .op         (op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .ready      (ready),
    .done       (done),
    .error      (error),
    ._ce_flash  (_ce_flash),
    ._oe_flash  (_oe_flash),
    ._we_flash  (_we_flash),
    .baddress   (baddress),
    .bdata_out  (bdata_out),
    .bdata_oe   (bdata_oe),
    .bdata_in   (bdata_in)
  );

  always #5 fast_clock = ~fast_clock;
  always @(posedge fast_clock) cyc++;

  logic [26:0] wr_q[$];
  logic [26:0] exp_q[$];
  int          pw_q[$];
  int          reads = 0, dones = 0, ce_cycles = 0, ce_wr_cycles = 0, viol = 0;
  int          cur_w = 0, last_hold_cyc = 0, done_cyc = 0, resp_polls = 1;
  logic        done_err = 1'b0, done_strobes = 1'b0, resp_target = 1'b1, resp_never = 1'b0;
  logic        we_prev = 1'b1, oe_prev = 1'b1;
  logic [18:0] poll_addr = '0;

  // Flash-side observer and DQ7 responder
  always @(negedge fast_clock) begin
    if (reset) begin
      we_prev = 1'b1;
      oe_prev = 1'b1;
    end else begin
      if (!_we_flash) begin
        if (we_prev) begin
          wr_q.push_back({baddress, bdata_out});
          cur_w = 0;
        end
        cur_w++;
        if (_ce_flash || !bdata_oe) viol++;
      end else if (!we_prev) begin
        pw_q.push_back(cur_w);
        last_hold_cyc = cyc;
      end
      if (!_oe_flash && !_we_flash) viol++;
      if (!_oe_flash && bdata_oe) viol++;
      if (!_oe_flash && oe_prev) begin
        reads++;
        if (reads == 1) poll_addr = baddress;
        bdata_in = {(!resp_never && reads >= resp_polls) ? resp_target : ~resp_target,
                    7'($urandom)};
      end
      if (!_ce_flash) begin
        ce_cycles++;
        if (reads == 0) ce_wr_cycles++;
      end
      if (done) begin
        dones++;
        done_cyc     = cyc;
        done_err     = error;
        done_strobes = _ce_flash & _oe_flash & _we_flash;
      end
      we_prev = _we_flash;
      oe_prev = _oe_flash;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_model(input logic [1:0] o, input logic [18:0] a,
                                      input logic [7:0] d);
    logic [18:0] sect;
    sect = {a[18:12], 12'h000};
    exp_q.delete();
    exp_q.push_back({19'h05555, 8'hAA});
    exp_q.push_back({19'h02AAA, 8'h55});
    if (o == 2'd0) begin
      exp_q.push_back({19'h05555, 8'hA0});
      exp_q.push_back({a, d});
    end else begin
      exp_q.push_back({19'h05555, 8'h80});
      exp_q.push_back({19'h05555, 8'hAA});
      exp_q.push_back({19'h02AAA, 8'h55});
      if (o == 2'd1) exp_q.push_back({sect, 8'h30});
      else           exp_q.push_back({19'h05555, 8'h10});
    end
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    pw_q.delete();
    reads = 0; dones = 0; ce_cycles = 0; ce_wr_cycles = 0; viol = 0;
    last_hold_cyc = 0; done_cyc = 0; done_err = 1'b0; done_strobes = 1'b0;
    poll_addr = '0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [18:0] a, input logic [7:0] d,
                       output int req_cyc);
    req = 1'b1; op = o; req_addr = a; req_data = d;
    req_cyc = cyc;
    @(negedge fast_clock);
    req = 1'b0;
    op = 2'($urandom); req_addr = 19'($urandom); req_data = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge fast_clock);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    @(negedge fast_clock);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [18:0] a, input logic [7:0] d,
                        input int polls, input logic never, input string tag);
    int rc;
    build_model(o, a, d);
    clear_mon();
    resp_polls  = polls;
    resp_never  = never;
    resp_target = (o == 2'd0) ? d[7] : 1'b1;
    issue(o, a, d, rc);
    check({tag, "_ready_low"}, ready, 0);
    wait_done(400, tag);
    check({tag, "_ready_back"}, ready, 1);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_error"}, done_err, never);
    check({tag, "_strobes_at_done"}, done_strobes, 1);
    check({tag, "_n_writes"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, $sformatf("_wr%0d", i)}, wr_q[i], exp_q[i]);
    for (int i = 0; i < pw_q.size(); i++)
      check({tag, $sformatf("_we_width%0d", i)}, pw_q[i], 4);
    check({tag, "_bus_phase"}, last_hold_cyc - rc, WR_CYC * exp_q.size());
    check({tag, "_ce_write_cycles"}, ce_wr_cycles, WR_CYC * exp_q.size());
    check({tag, "_pin_rules"}, viol, 0);
    if (never) begin
      check({tag, "_poll_len"}, done_cyc - last_hold_cyc, TMO + 1);
      check({tag, "_poll_reads"}, reads, (TMO + POLL_PER - 1) / POLL_PER);
    end else begin
      check({tag, "_poll_reads"}, reads, polls);
      if (o != 2'd2)
        check({tag, "_poll_addr"}, poll_addr, (o == 2'd0) ? a : {a[18:12], 12'h000});
    end
  endtask

  initial begin
    int rc, n;
    logic [1:0] ro;
    logic [18:0] ra;
    logic [7:0] rd;

    repeat (3) @(negedge fast_clock);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_strobes", {_ce_flash, _oe_flash, _we_flash}, 3'b111);
    check("rst_bdata_oe", bdata_oe, 0);
    check("rst_baddress", baddress, 0);
    check("rst_bdata_out", bdata_out, 0);
    reset = 1'b0;
    @(negedge fast_clock);

    run_op(2'd0, 19'h01234, 8'h5A, 3, 1'b0, "prog");
    run_op(2'd1, 19'h7F123, 8'h00, 2, 1'b0, "sect");
    run_op(2'd2, 19'h00000, 8'hFF, 1, 1'b0, "chip");
    run_op(2'd0, 19'h2468A, 8'hA7, 1, 1'b1, "timeout");

    // Illegal op: immediate done+error, no bus activity
    clear_mon();
    issue(2'd3, 19'h3C3C3, 8'h81, rc);
    check("illegal_done", done, 1);
    check("illegal_error", error, 1);
    check("illegal_ready_low", ready, 0);
    @(negedge fast_clock);
    check("illegal_done_drop", done, 0);
    check("illegal_ready_back", ready, 1);
    repeat (3) @(negedge fast_clock);
    check("illegal_no_ce", ce_cycles, 0);
    check("illegal_done_count", dones, 1);

    // Reset and req together: reset wins, req is not remembered
    reset = 1'b1; req = 1'b1; op = 2'd0;
    @(negedge fast_clock);
    reset = 1'b0; req = 1'b0;
    check("rst_req_ready", ready, 1);
    check("rst_req_ce", _ce_flash, 1);
    @(negedge fast_clock);
    check("rst_req_ignored", ready, 1);

    // Reset during the third _we pulse
    clear_mon();
    resp_polls = 1; resp_never = 1'b0; resp_target = 1'b1;
    issue(2'd0, 19'h42345, 8'hC3, rc);
    n = 0;
    while (!(pw_q.size() == 2 && !_we_flash) && n < 200) begin
      @(negedge fast_clock);
      n++;
    end
    check("rst_mid_in_pulse", _we_flash, 0);
    reset = 1'b1;
    @(negedge fast_clock);
    check("rst_mid_strobes", {_ce_flash, _oe_flash, _we_flash}, 3'b111);
    check("rst_mid_bdata_oe", bdata_oe, 0);
    check("rst_mid_ready", ready, 1);
    reset = 1'b0;
    @(negedge fast_clock);
    run_op(2'd0, 19'h42345, 8'hC3, 2, 1'b0, "after_rst");

    // Stray requests while busy are dropped
    build_model(2'd1, 19'h51234, 8'h00);
    clear_mon();
    resp_polls = 2; resp_never = 1'b0; resp_target = 1'b1;
    issue(2'd1, 19'h51234, 8'h00, rc);
    repeat (5) @(negedge fast_clock);
    req = 1'b1; op = 2'd3;
    @(negedge fast_clock);
    req = 1'b0;
    repeat (6) @(negedge fast_clock);
    req = 1'b1; op = 2'd0;
    @(negedge fast_clock);
    req = 1'b0;
    wait_done(400, "busy_req");
    check("busy_req_error", done_err, 0);
    check("busy_req_writes", wr_q.size(), exp_q.size());
    repeat (4) @(negedge fast_clock);
    check("busy_req_done_count", dones, 1);
    check("busy_req_idle", ready, 1);

    for (int k = 0; k < 6; k++) begin
      ro = 2'($urandom_range(0, 2));
      ra = 19'($urandom);
      rd = 8'($urandom);
      run_op(ro, ra, rd, int'($urandom_range(1, 4)), 1'b0, $sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
